// File: rtl/arith_pkg.sv
// Shared arithmetic-library types and constants.
package arith_pkg;

    localparam int unsigned ARITH_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: diff = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b - bin) over WIDTH cycles with start/done handshake.
// Optional signed overflow flag enabled by defining SERIAL_SUB_SIGNED_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_EN
    output logic             overflow,
`endif
    output logic             borrow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sub_state_t       state, state_next;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             bf;
    logic [CNT_W-1:0] cnt;
    logic             load, step, last;
    logic             d, bo;

`ifdef SERIAL_SUB_SIGNED_EN
    logic             a_msb, b_msb;
`endif

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bf),
        .diff (d),
        .bout (bo)
    );

    // New bit enters at the top; the low WIDTH-1 bits of the result are kept in sr.
    assign sr_next = {d, sr};

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            bf     <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= last;
            if (load) begin
                sa  <= a;
                sb  <= b;
                bf  <= bin;
                cnt <= '0;
            end else if (step) begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                sr <= sr_next[WIDTH-1:1];
                bf <= bo;
                if (!last) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // Result registers hold until the next completion.
            if (last) begin
                diff   <= sr_next;
                borrow <= bo;
            end
        end
    end

`ifdef SERIAL_SUB_SIGNED_EN
    // Operand sign bits are kept separately since sa/sb are shifted away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (last) begin
                overflow <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); define SERIAL_SUB_SIGNED_EN to cover overflow.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_SIGNED_EN
    logic         overflow;
`endif

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
`ifdef SERIAL_SUB_SIGNED_EN
        .overflow (overflow),
`endif
        .borrow   (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction of the accepted operands.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                          input int disturb_at);
        int           r;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        r  = int'(oa) - int'(ob) - int'(obin);
        ed = W'(r);
        eb = (r < 0);
        eo = (oa[W-1] != ob[W-1]) && (ed[W-1] != oa[W-1]);
        a     = oa;
        b     = ob;
        bin   = obin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("done_after_accept", 32'(done), 32'd0);
        for (int k = 1; k <= int'(W); k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == disturb_at) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
            end
            if (k < int'(W)) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_early", 32'(done), 32'd0);
            end else begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
                chk("diff", 32'(diff), 32'(ed));
                chk("borrow", 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_EN
                chk("overflow", 32'(overflow), 32'(eo));
`else
                if (eo) r = 0;
`endif
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("done_deassert", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_SIGNED_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h50, 8'h20, 1'b0, 0);
        idle_cycle();
        run_op(8'h20, 8'h50, 1'b0, 0);
        idle_cycle();
        run_op(8'h00, 8'h00, 1'b1, 0);
        idle_cycle();

        // Back-to-back: second start lands in the DONE cycle, plus an ignored start mid-run.
        run_op(8'h40, 8'h11, 1'b0, 0);
        run_op(8'h05, 8'h03, 1'b0, 3);
        idle_cycle();

        // Operand change right after acceptance.
        run_op(8'hA7, 8'h3C, 1'b1, 1);
        idle_cycle();

        // Reset at cycle 4 of RUN: outputs clear immediately and no done follows.
        a     = 8'h77;
        b     = 8'h22;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_SIGNED_EN
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (done || busy) seen++;
            end
            chk("no_done_after_rst", 32'(seen), 32'd0);
        end

        // Signed-overflow corner cases (also checked for diff/borrow without the option).
        run_op(8'h80, 8'h01, 1'b0, 0);
        idle_cycle();
        run_op(8'h10, 8'h01, 1'b0, 0);
        idle_cycle();

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
